// File: rtl/pipe_div_inv.sv
// Sequential restoring divider: recovers X3 = F / D from a multiply-pipeline product, one bit per clock.
// Optional macro PIPE_DIV_INV_EARLY_EN: D==0 or F==0 bypass BUSY and complete one cycle after acceptance.
module pipe_div_inv #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] X3,
  output logic [N-1:0] R,
  output logic         dz
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   f_q, d_q, quo, quo_nxt;
  logic [N:0]     rem, rem_sh, rem_nxt;
  logic [CW-1:0]  cnt;
  logic           dz_q, accept, early, q_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);

`ifdef PIPE_DIV_INV_EARLY_EN
  assign early = (D == '0) || (F == '0);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract D when it fits.
  assign rem_sh  = (rem << 1) | (N+1)'(f_q[N-1]);
  assign q_bit   = (rem_sh >= {1'b0, d_q});
  assign rem_nxt = q_bit ? (rem_sh - {1'b0, d_q}) : rem_sh;
  assign quo_nxt = (quo << 1) | N'(q_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q  <= '0;
      d_q  <= '0;
      quo  <= '0;
      rem  <= '0;
      cnt  <= '0;
      dz_q <= 1'b0;
      X3   <= '0;
      R    <= '0;
      dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          f_q  <= F;
          d_q  <= D;
          dz_q <= (D == '0);
          rem  <= '0;
          quo  <= '0;
          cnt  <= CW'(N-1);
          if (early) begin
            // Same values the full iteration would produce for these operands.
            X3 <= (D == '0) ? '1 : '0;
            R  <= (D == '0) ? F  : '0;
            dz <= (D == '0);
          end
        end
        BUSY: begin
          f_q <= f_q << 1;
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            X3 <= quo_nxt;
            R  <= rem_nxt[N-1:0];
            dz <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_div_inv.sv
// Directed bench for pipe_div_inv: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_pipe_div_inv;
  localparam int N = 10;
  localparam int P = 10;

  typedef struct packed {
    logic [N-1:0] x3;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] F = '0;
  logic [N-1:0] D = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] X3, R;
  logic         dz;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  time  last_acc = 0;

  pipe_div_inv #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .F(F), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .X3(X3), .R(R), .dz(dz)
  );

  always #(P/2) clk = ~clk;

  // Monitor: one comparison per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL result: unexpected output X3=%0d R=%0d dz=%0d", X3, R, dz);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (X3 !== e.x3 || R !== e.r || dz !== e.dz) begin
          n_bad++;
          $display("FAIL result: got X3=%0d R=%0d dz=%0d, want X3=%0d R=%0d dz=%0d",
                   X3, R, dz, e.x3, e.r, e.dz);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one operation, push its expected result, and return #1 after out_valid first rises.
  task automatic send(input logic [N-1:0] f, input logic [N-1:0] d,
                      input logic [N-1:0] ex, input logic [N-1:0] er, input logic edz,
                      input int lat, input bit chk_gap);
    int k;
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1; F = f; D = d;
    sb.push_back('{x3: ex, r: er, dz: edz});
    @(posedge clk);
    if (chk_gap) check("accept_gap_cycles", int'(($time - last_acc) / P), N + 2);
    last_acc = $time;
    #1;
    in_valid = 1'b0; F = '1; D = '0;
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("latency", k, lat);
  endtask

  initial begin
    int zlat;
`ifdef PIPE_DIV_INV_EARLY_EN
    zlat = 1;
`else
    zlat = N;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x3_r_dz", int'({X3, R, dz}), 0);

    out_ready = 1'b1;
    send(10'd75, 10'd3, 10'd25, 10'd0, 1'b0, N, 1'b0);

    // Back-to-back with out_ready high: N+2 cycle spacing between acceptances.
    send(10'd66,   10'd3, 10'd22,  10'd0, 1'b0, N, 1'b1);
    send(10'd112,  10'd4, 10'd28,  10'd0, 1'b0, N, 1'b1);
    send(10'd62,   10'd2, 10'd31,  10'd0, 1'b0, N, 1'b1);
    send(10'd1000, 10'd7, 10'd142, 10'd6, 1'b0, N, 1'b1);

    send(10'd1023, 10'd1, 10'd1023, 10'd0, 1'b0, N, 1'b0);
    send(10'd5,    10'd9, 10'd0,    10'd5, 1'b0, N, 1'b0);
    send(10'd49,   10'd0, 10'd1023, 10'd49, 1'b1, zlat, 1'b0);

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(10'd100, 10'd7, 10'd14, 10'd2, 1'b0, N, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("bp_x3", int'(X3), 14);
      check("bp_r", int'(R), 2);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      in_valid = i[0]; F = 10'd3; D = 10'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", int'(in_ready), 1);
    check("bp_idle_out_valid", int'(out_valid), 0);

    // Reset four cycles into BUSY discards the operation.
    in_valid = 1'b1; F = 10'd75; D = 10'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_x3", int'(X3), 0);
    check("mid_rst_r", int'(R), 0);
    check("mid_rst_dz", int'(dz), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(10'd75, 10'd3, 10'd25, 10'd0, 1'b0, N, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(P * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_div_inv.md
# pipe_div_inv

Sequential inverse of the three-stage multiply pipeline. It takes a product word F and the multiplier D that pipeline consumed, and recovers the stage-2 sum X3 = F / D with an N-cycle restoring divider. It sits downstream of the pipeline as a checker/decoder stage. Transfers use a valid/ready handshake on both sides, and the block holds one transaction at a time.

## Interface
- N, 10, operand/result width in bits (N >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  F/D presented
- in_ready  output  1  block can accept; high only in IDLE
- F  input  N  dividend (pipeline product)
- D  input  N  divisor (pipeline multiplier)
- out_valid  output  1  result available; high only in DONE
- out_ready  input  1  downstream accepts result
- X3  output  N  quotient F / D (unsigned, truncating)
- R  output  N  remainder F mod D
- dz  output  1  divisor was zero for this result

## Operation
- **States:** IDLE, BUSY, DONE. Reset (rst_n low, asynchronous) forces IDLE.
- **Reset values:** X3=0, R=0, dz=0, out_valid=0, in_ready=1 once reset is released. The iteration counter and internal registers also clear.
- **IDLE:**
  - On in_valid && in_ready, capture F and D, set dz = (D==0), clear the partial remainder, load the counter with N-1, and go to BUSY.
  - F and D are ignored when in_valid is low.
- **BUSY:** one restoring step per clock, MSB first.
  - rem' = {rem, F[i]}, held in N+1 bits.
  - If rem' >= D: rem' -= D and quotient bit i = 1; otherwise quotient bit i = 0.
  - After the step with counter==0, load X3/R and go to DONE.
- **Arithmetic:** unsigned and exact. The partial remainder is N+1 bits wide, so no overflow is possible for any F, D.
- **D==0:** the natural restoring result applies: X3 = 2^N-1 and R = F, with dz=1. No special-casing of the datapath is needed.
- **DONE:**
  - out_valid=1; X3, R and dz are held stable until out_valid && out_ready.
  - Then go to IDLE; in_ready rises on the following cycle.
- **Inputs outside IDLE:** in_valid is ignored while BUSY or DONE. No second operation is queued.
- **Reset mid-operation:** the in-flight operation is discarded with no output produced. The first cycle after reset release is IDLE.

## Timing
- The acceptance edge is edge 0.
- Division steps occur on edges 1..N, so out_valid is high after edge N: latency is N cycles from acceptance.
- With out_ready held high:
  - The handshake completes on edge N+1.
  - in_ready is high after edge N+1.
  - The next acceptance can be no earlier than edge N+2, giving a throughput of one result per N+2 cycles.
- X3, R and dz change only on the edge that enters DONE. They are registered outputs.
- in_ready and out_valid are decoded directly from state registers. There is no combinational path from any input to any output.

## Configuration
- Macro: PIPE_DIV_INV_EARLY_EN.
- **Defined:** when D==0 or F==0 at acceptance, the block skips BUSY and goes directly to DONE on edge 1, so out_valid is high after 1 cycle.
  - D==0 gives X3 = 2^N-1, R = F, dz=1.
  - F==0 with D!=0 gives X3=0, R=0, dz=0.
  - All other operands take N cycles as normal.
- **Undefined:** every operation takes exactly N cycles and produces the identical results.
- Results are identical in both builds; only latency differs.

## Test plan
- F=75, D=3, out_ready=1 -> X3=25, R=0, dz=0; out_valid is high exactly 10 cycles after the acceptance edge.
- Back-to-back (F,D) = (66,3), (112,4), (62,2), (1000,7) -> X3/R of 22/0, 28/0, 31/0, 142/6; each acceptance is 12 cycles after the previous one.
- F=1023, D=1, then F=5, D=9 -> 1023/0, then 0/5.
- F=49, D=0 -> X3=1023, R=49, dz=1. Latency is 10 cycles without PIPE_DIV_INV_EARLY_EN and 1 cycle with it.
- Backpressure: F=100, D=7 with out_ready low for 6 cycles after out_valid -> X3=14, R=2 stay stable and in_ready stays low; in_valid pulses during this window are ignored; IDLE is entered on the edge after out_ready rises.
- rst_n pulsed low 4 cycles into BUSY -> all outputs return to 0 and in_ready=1 immediately. A fresh F=75, D=3 after release yields 25/0 with the normal latency.
